// File: rtl/multicycle_controller_pkg.sv
// Shared definitions for the multicycle LEGv8-style controller.
// Contents:
//   state_t      - FSM state encodings (visible on the controller's state port)
//   opclass_t    - instruction class produced by opcode_decoder
//   OP_*         - full opcodes and prefix patterns recognised by the decoder
//   PC_SRC_*     - pc_src select codes
//   ALUB_*       - alu_src_b select codes
//   ALUOP_*      - alu_op codes
package multicycle_controller_pkg;

    localparam int OPCODE_W = 11;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_EXEC_R  = 4'd2,
        S_ADDR    = 4'd3,
        S_MEM_RD  = 4'd4,
        S_MEM_WR  = 4'd5,
        S_WB_R    = 4'd6,
        S_WB_MEM  = 4'd7,
        S_BR_CB   = 4'd8,
        S_BR_B    = 4'd9,
        S_ILLEGAL = 4'd15
    } state_t;

    typedef enum logic [2:0] {
        C_R   = 3'd0,
        C_LD  = 3'd1,
        C_ST  = 3'd2,
        C_CB  = 3'd3,
        C_B   = 3'd4,
        C_BAD = 3'd5
    } opclass_t;

    // Full 11-bit opcodes
    localparam logic [OPCODE_W-1:0] OP_ADD  = 11'b10001011000;
    localparam logic [OPCODE_W-1:0] OP_SUB  = 11'b11001011000;
    localparam logic [OPCODE_W-1:0] OP_AND  = 11'b10001010000;
    localparam logic [OPCODE_W-1:0] OP_ORR  = 11'b10101010000;
    localparam logic [OPCODE_W-1:0] OP_LDUR = 11'b11111000010;
    localparam logic [OPCODE_W-1:0] OP_STUR = 11'b11111000000;

    // Branch opcodes are shorter; the remaining bits belong to the immediate
    localparam logic [7:0] OP_CBZ_PFX = 8'b10110100;
    localparam logic [5:0] OP_B_PFX   = 6'b000101;

    localparam logic [1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] PC_SRC_BRANCH = 2'b01;
    localparam logic [1:0] PC_SRC_UNCOND = 2'b10;

    localparam logic [1:0] ALUB_REG  = 2'b00;
    localparam logic [1:0] ALUB_FOUR = 2'b01;
    localparam logic [1:0] ALUB_IMM  = 2'b10;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

endpackage

// File: rtl/opcode_decoder.sv
// Combinational opcode classifier.
// Ports:
//   opcode  in  11  opcode field of the instruction register
//   opclass out 3   R / LD / ST / CB / B / BAD
module opcode_decoder
    import multicycle_controller_pkg::*;
(
    input  logic [OPCODE_W-1:0] opcode,
    output opclass_t            opclass
);

    always_comb begin
        opclass = C_BAD;
        if (opcode == OP_ADD || opcode == OP_SUB ||
            opcode == OP_AND || opcode == OP_ORR) begin
            opclass = C_R;
        end else if (opcode == OP_LDUR) begin
            opclass = C_LD;
        end else if (opcode == OP_STUR) begin
            opclass = C_ST;
        end else if (opcode[10:3] == OP_CBZ_PFX) begin
            opclass = C_CB;
        end else if (opcode[10:5] == OP_B_PFX) begin
            opclass = C_B;
        end
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle datapath controller (FETCH / DECODE / execute / memory / writeback).
// Ports:
//   clock, reset          rising-edge clock, asynchronous active-high reset
//   opcode, zero          instruction opcode field, ALU zero flag
//   mem_ready             memory completes the current request this cycle
//   mem_req/mem_write/iord             memory request, write enable, address select
//   pc_write/ir_write/reg_write        one-cycle datapath strobes
//   mem_to_reg/reg2loc/alu_src_a       datapath selects
//   pc_src/alu_src_b/alu_op            2-bit datapath selects
//   state                              current state encoding
//   illegal                            set while parked in ILLEGAL
// All outputs are a combinational decode of the state register; reset also
// gates them to zero directly so they drop in the same cycle it is asserted.
module multicycle_controller
    import multicycle_controller_pkg::*;
#(
    parameter int OPC_W = OPCODE_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [OPC_W-1:0] opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_write,
    output logic             iord,
    output logic             pc_write,
    output logic             ir_write,
    output logic             reg_write,
    output logic             mem_to_reg,
    output logic             reg2loc,
    output logic             alu_src_a,
    output logic [1:0]       pc_src,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [3:0]       state,
    output logic             illegal
);

    state_t   state_reg;
    state_t   state_next;
    opclass_t opclass;

    opcode_decoder u_decoder (
        .opcode  (opcode),
        .opclass (opclass)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg <= S_FETCH;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        mem_req    = 1'b0;
        mem_write  = 1'b0;
        iord       = 1'b0;
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        reg2loc    = 1'b0;
        alu_src_a  = 1'b0;
        pc_src     = PC_SRC_ALU;
        alu_src_b  = ALUB_REG;
        alu_op     = ALUOP_ADD;
        illegal    = 1'b0;
        if (!reset) begin
            case (state_reg)
                S_FETCH: begin
                    // PC+4 is computed every cycle but only committed, together
                    // with the IR load, in the cycle the memory answers.
                    mem_req   = 1'b1;
                    alu_src_b = ALUB_FOUR;
                    pc_write  = mem_ready;
                    ir_write  = mem_ready;
                    if (mem_ready) begin
                        state_next = S_DECODE;
                    end
                end
                S_DECODE: begin
                    case (opclass)
                        C_R:          state_next = S_EXEC_R;
                        C_LD, C_ST:   state_next = S_ADDR;
                        C_CB:         state_next = S_BR_CB;
                        C_B:          state_next = S_BR_B;
                        default:      state_next = S_ILLEGAL;
                    endcase
                end
                S_EXEC_R: begin
                    alu_src_a  = 1'b1;
                    alu_src_b  = ALUB_REG;
                    alu_op     = ALUOP_FUNCT;
                    state_next = S_WB_R;
                end
                S_WB_R: begin
                    reg_write  = 1'b1;
                    state_next = S_FETCH;
                end
                S_ADDR: begin
                    alu_src_a  = 1'b1;
                    alu_src_b  = ALUB_IMM;
                    alu_op     = ALUOP_ADD;
                    state_next = (opclass == C_ST) ? S_MEM_WR : S_MEM_RD;
                end
                S_MEM_RD: begin
                    mem_req = 1'b1;
                    iord    = 1'b1;
                    if (mem_ready) begin
                        state_next = S_WB_MEM;
                    end
                end
                S_MEM_WR: begin
                    mem_req   = 1'b1;
                    iord      = 1'b1;
                    mem_write = 1'b1;
                    if (mem_ready) begin
                        state_next = S_FETCH;
                    end
                end
                S_WB_MEM: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                    state_next = S_FETCH;
                end
                S_BR_CB: begin
                    // Rt is read through the second register port so the ALU
                    // can test it against zero.
                    reg2loc    = 1'b1;
                    alu_op     = ALUOP_SUB;
                    pc_write   = zero;
                    pc_src     = zero ? PC_SRC_BRANCH : PC_SRC_ALU;
                    state_next = S_FETCH;
                end
                S_BR_B: begin
                    pc_write   = 1'b1;
                    pc_src     = PC_SRC_UNCOND;
                    state_next = S_FETCH;
                end
                S_ILLEGAL: begin
                    illegal = 1'b1;
                end
                default: begin
                    // Unused encodings park in ILLEGAL rather than wander.
                    state_next = S_ILLEGAL;
                end
            endcase
        end
    end

    assign state = state_reg;

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomised scoreboard bench for multicycle_controller.
module tb_multicycle_controller;

    typedef enum int {
        P_RESET, P_FETCH, P_DECODE, P_EXEC, P_WBR, P_ADDR,
        P_MRD, P_MWR, P_WBM, P_CB, P_B, P_ILL
    } phase_t;

    typedef struct packed {
        logic [3:0] state;
        logic       mem_req;
        logic       mem_write;
        logic       iord;
        logic       pc_write;
        logic       ir_write;
        logic       reg_write;
        logic       mem_to_reg;
        logic       reg2loc;
        logic       alu_src_a;
        logic [1:0] pc_src;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       illegal;
    } obs_t;

    typedef struct {
        obs_t   exp;
        obs_t   care;
        phase_t ph;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [10:0] opcode = '0;
    logic        zero = 1'b0;
    logic        mem_ready = 1'b0;
    logic        mem_req, mem_write, iord, pc_write, ir_write, reg_write;
    logic        mem_to_reg, reg2loc, alu_src_a, illegal;
    logic [1:0]  pc_src, alu_src_b, alu_op;
    logic [3:0]  state;

    obs_t act;
    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    multicycle_controller #(.OPC_W(11)) dut (
        .clock      (clock),
        .reset      (reset),
        .opcode     (opcode),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .mem_req    (mem_req),
        .mem_write  (mem_write),
        .iord       (iord),
        .pc_write   (pc_write),
        .ir_write   (ir_write),
        .reg_write  (reg_write),
        .mem_to_reg (mem_to_reg),
        .reg2loc    (reg2loc),
        .alu_src_a  (alu_src_a),
        .pc_src     (pc_src),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .state      (state),
        .illegal    (illegal)
    );

    always #5 clock = ~clock;

    assign act = {state, mem_req, mem_write, iord, pc_write, ir_write, reg_write,
                  mem_to_reg, reg2loc, alu_src_a, pc_src, alu_src_b, alu_op, illegal};

    // Instruction classes straight from the opcode table:
    // 0 R, 1 LDUR, 2 STUR, 3 CBZ, 4 B, 5 bad
    function automatic int classify(logic [10:0] op);
        if (op == 11'b10001011000 || op == 11'b11001011000 ||
            op == 11'b10001010000 || op == 11'b10101010000) return 0;
        if (op == 11'b11111000010) return 1;
        if (op == 11'b11111000000) return 2;
        if (op[10:3] == 8'b10110100) return 3;
        if (op[10:5] == 6'b000101) return 4;
        return 5;
    endfunction

    // Required outputs for one cycle of a given instruction phase.
    // Selects that the behaviour leaves open are marked don't-care.
    function automatic exp_t expect_for(phase_t ph, logic mr, logic z);
        exp_t e;
        e.ph   = ph;
        e.exp  = '0;
        e.care = '1;
        if (ph != P_RESET) begin
            e.care.iord       = 1'b0;
            e.care.mem_to_reg = 1'b0;
            e.care.reg2loc    = 1'b0;
            e.care.alu_src_a  = 1'b0;
            e.care.pc_src     = 2'b00;
            e.care.alu_src_b  = 2'b00;
            e.care.alu_op     = 2'b00;
        end
        case (ph)
            P_FETCH: begin
                e.exp.state      = 4'd0;
                e.exp.mem_req    = 1'b1;
                e.care.iord      = 1'b1;
                e.care.alu_src_a = 1'b1;
                e.exp.alu_src_b  = 2'b01;
                e.care.alu_src_b = 2'b11;
                e.care.alu_op    = 2'b11;
                e.exp.pc_write   = mr;
                e.exp.ir_write   = mr;
                if (mr) e.care.pc_src = 2'b11;
            end
            P_DECODE: e.exp.state = 4'd1;
            P_EXEC: begin
                e.exp.state      = 4'd2;
                e.care.alu_src_b = 2'b11;
                e.exp.alu_op     = 2'b10;
                e.care.alu_op    = 2'b11;
            end
            P_WBR: begin
                e.exp.state       = 4'd6;
                e.exp.reg_write   = 1'b1;
                e.care.mem_to_reg = 1'b1;
            end
            P_ADDR: begin
                e.exp.state      = 4'd3;
                e.exp.alu_src_b  = 2'b10;
                e.care.alu_src_b = 2'b11;
                e.care.alu_op    = 2'b11;
            end
            P_MRD: begin
                e.exp.state   = 4'd4;
                e.exp.mem_req = 1'b1;
                e.exp.iord    = 1'b1;
                e.care.iord   = 1'b1;
            end
            P_MWR: begin
                e.exp.state     = 4'd5;
                e.exp.mem_req   = 1'b1;
                e.exp.mem_write = 1'b1;
                e.exp.iord      = 1'b1;
                e.care.iord     = 1'b1;
            end
            P_WBM: begin
                e.exp.state       = 4'd7;
                e.exp.reg_write   = 1'b1;
                e.exp.mem_to_reg  = 1'b1;
                e.care.mem_to_reg = 1'b1;
            end
            P_CB: begin
                e.exp.state     = 4'd8;
                e.exp.reg2loc   = 1'b1;
                e.care.reg2loc  = 1'b1;
                e.exp.alu_op    = 2'b01;
                e.care.alu_op   = 2'b11;
                e.exp.pc_write  = z;
                if (z) begin
                    e.exp.pc_src  = 2'b01;
                    e.care.pc_src = 2'b11;
                end
            end
            P_B: begin
                e.exp.state    = 4'd9;
                e.exp.pc_write = 1'b1;
                e.exp.pc_src   = 2'b10;
                e.care.pc_src  = 2'b11;
            end
            P_ILL: begin
                e.exp.state   = 4'd15;
                e.exp.illegal = 1'b1;
            end
            default: ;
        endcase
        return e;
    endfunction

    // Monitor: compares every cycle that has an expectation queued.
    always @(negedge clock) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            checks++;
            if (((act ^ e.exp) & e.care) != '0) begin
                errors++;
                $display("FAIL outputs cyc=%0d phase=%s actual=%05h required=%05h care=%05h",
                         cyc, e.ph.name(), act, e.exp, e.care);
            end
        end
    end

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic drive_cycle(logic [10:0] op, phase_t ph, logic mr, logic z);
        @(posedge clock);
        #1;
        reset     = 1'b0;
        opcode    = op;
        mem_ready = mr;
        zero      = z;
        cyc++;
        q.push_back(expect_for(ph, mr, z));
    endtask

    task automatic do_reset(int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
            reset     = 1'b1;
            mem_ready = rbit();
            cyc++;
            q.push_back(expect_for(P_RESET, 1'b0, 1'b0));
        end
        $display("reset held %0d cycles", n);
    endtask

    task automatic run_instr(logic [10:0] op, logic z, int fw, int mw);
        int cls;
        int n;
        cls = classify(op);
        n   = 0;
        for (int i = 0; i < fw; i++) begin
            drive_cycle(op, P_FETCH, 1'b0, rbit());
            n++;
        end
        drive_cycle(op, P_FETCH, 1'b1, rbit());
        drive_cycle(op, P_DECODE, rbit(), rbit());
        n += 2;
        case (cls)
            0: begin
                drive_cycle(op, P_EXEC, rbit(), rbit());
                drive_cycle(op, P_WBR, rbit(), rbit());
                n += 2;
            end
            1, 2: begin
                drive_cycle(op, P_ADDR, rbit(), rbit());
                n++;
                for (int i = 0; i < mw; i++) begin
                    drive_cycle(op, (cls == 1) ? P_MRD : P_MWR, 1'b0, rbit());
                    n++;
                end
                drive_cycle(op, (cls == 1) ? P_MRD : P_MWR, 1'b1, rbit());
                n++;
                if (cls == 1) begin
                    drive_cycle(op, P_WBM, rbit(), rbit());
                    n++;
                end
            end
            3: begin
                drive_cycle(op, P_CB, rbit(), z);
                n++;
            end
            4: begin
                drive_cycle(op, P_B, rbit(), rbit());
                n++;
            end
            default: begin
                for (int i = 0; i < 10; i++) begin
                    drive_cycle(op, P_ILL, rbit(), rbit());
                    n++;
                end
            end
        endcase
        $display("instr class=%0d op=%b zero=%0b fetch_wait=%0d mem_wait=%0d cycles=%0d",
                 cls, op, z, fw, mw, n);
        if (cls == 5) do_reset(1 + $urandom_range(0, 1));
    endtask

    // Reset arriving mid-cycle while a store waits on memory.
    task automatic reset_in_mem_wr();
        logic [10:0] op;
        op = 11'b11111000000;
        drive_cycle(op, P_FETCH, 1'b1, 1'b0);
        drive_cycle(op, P_DECODE, 1'b1, 1'b0);
        drive_cycle(op, P_ADDR, 1'b0, 1'b0);
        drive_cycle(op, P_MWR, 1'b0, 1'b0);
        drive_cycle(op, P_MWR, 1'b0, 1'b0);
        @(negedge clock);
        #1;
        reset = 1'b1;
        #1;
        checks++;
        if (act != '0) begin
            errors++;
            $display("FAIL async_reset_mem_wr actual=%05h required=00000", act);
        end
        @(posedge clock);
        #1;
        cyc++;
        q.push_back(expect_for(P_RESET, 1'b0, 1'b0));
        $display("instr STUR abandoned by reset in MEM_WR");
    endtask

    function automatic logic [10:0] gen_op(int kind);
        logic [10:0] rops [4];
        logic [10:0] op;
        rops = '{11'b10001011000, 11'b11001011000, 11'b10001010000, 11'b10101010000};
        case (kind)
            0:       op = rops[$urandom_range(0, 3)];
            1:       op = 11'b11111000010;
            2:       op = 11'b11111000000;
            3:       op = {8'b10110100, 3'($urandom_range(0, 7))};
            4:       op = {6'b000101, 5'($urandom_range(0, 31))};
            default: begin
                op = 11'($urandom);
                while (classify(op) != 5) op = 11'($urandom);
            end
        endcase
        return op;
    endfunction

    initial begin
        int kind;
        do_reset(2);
        // Directed cases
        run_instr(11'b10001011000, 1'b0, 0, 0);          // ADD
        run_instr(11'b11111000010, 1'b0, 0, 2);          // LDUR, 2 wait cycles
        run_instr(11'b10110100011, 1'b1, 0, 0);          // CBZ taken
        run_instr(11'b10110100000, 1'b0, 0, 0);          // CBZ not taken
        run_instr(11'b11111000000, 1'b0, 0, 0);          // STUR
        run_instr(11'b00010110101, 1'b0, 0, 0);          // B back-to-back
        run_instr(11'b11111111111, 1'b0, 0, 0);          // illegal, then reset
        reset_in_mem_wr();
        run_instr(11'b10101010000, 1'b0, 1, 0);          // ORR after reset
        // Random mix
        for (int i = 0; i < 80; i++) begin
            kind = ($urandom_range(0, 15) == 0) ? 5 : int'($urandom_range(0, 4));
            run_instr(gen_op(kind), rbit(), int'($urandom_range(0, 2)),
                      int'($urandom_range(0, 3)));
        end
        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clock);
        #1;
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain pending=%0d required=0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
